// File: rtl/modexp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : modexp_arbiter_if
// Purpose  : Requester, key and engine signals shared by the modexp arbiter.
// Revision : 1.0
// ============================================================================
interface modexp_arbiter_if #(
    parameter int WIDTH = 512
);
    logic             keys_valid_in;
    logic [WIDTH-1:0] e_in;
    logic [WIDTH-1:0] local_d_in;
    logic [WIDTH-1:0] local_N_in;
    logic [WIDTH-1:0] other_N_in;

    logic             enc_valid_in;
    logic [WIDTH-1:0] enc_msg_in;
    logic             enc_ready_out;
    logic             enc_valid_out;
    logic [WIDTH-1:0] enc_result_out;
    logic             enc_error_out;

    logic             dec_valid_in;
    logic [WIDTH-1:0] dec_msg_in;
    logic             dec_ready_out;
    logic             dec_valid_out;
    logic [WIDTH-1:0] dec_result_out;
    logic             dec_error_out;

    logic             eng_valid_out;
    logic [WIDTH-1:0] eng_base_out;
    logic [WIDTH-1:0] eng_exp_out;
    logic [WIDTH-1:0] eng_mod_out;
    logic             eng_busy_in;
    logic             eng_valid_in;
    logic [WIDTH-1:0] eng_result_in;
    logic             eng_abort_out;

    modport slave (
        input  keys_valid_in, e_in, local_d_in, local_N_in, other_N_in,
        input  enc_valid_in, enc_msg_in, dec_valid_in, dec_msg_in,
        output enc_ready_out, enc_valid_out, enc_result_out, enc_error_out,
        output dec_ready_out, dec_valid_out, dec_result_out, dec_error_out,
        output eng_valid_out, eng_base_out, eng_exp_out, eng_mod_out, eng_abort_out,
        input  eng_busy_in, eng_valid_in, eng_result_in
    );

    modport master (
        output keys_valid_in, e_in, local_d_in, local_N_in, other_N_in,
        output enc_valid_in, enc_msg_in, dec_valid_in, dec_msg_in,
        input  enc_ready_out, enc_valid_out, enc_result_out, enc_error_out,
        input  dec_ready_out, dec_valid_out, dec_result_out, dec_error_out,
        input  eng_valid_out, eng_base_out, eng_exp_out, eng_mod_out, eng_abort_out,
        output eng_busy_in, eng_valid_in, eng_result_in
    );
endinterface
`default_nettype wire

// File: rtl/modexp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : modexp_arbiter
// Purpose  : Round-robin sharing of one modexp engine between encrypt and
//            decrypt requesters. Optional MODEXP_TIMEOUT_EN adds a watchdog.
// Revision : 1.0
// ============================================================================
module modexp_arbiter #(
    parameter int WIDTH          = 512,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  wire logic         clk_in,
    input  wire logic         rst_in,
    modexp_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_enc_full;
    logic               r_dec_full;
    logic [WIDTH-1:0]   r_enc_buf;
    logic [WIDTH-1:0]   r_dec_buf;
    logic               r_last_dec;
    logic               r_gnt_dec;
    logic               r_timed_out;

    logic               w_grant;
    logic               w_pick_dec;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_exp;
    logic [WIDTH-1:0]   w_mod;
    logic               w_range_err;
    logic               w_fin;
    logic               w_fin_dec;
    logic               w_fin_err;
    logic [WIDTH-1:0]   w_fin_res;

    assign bus.enc_ready_out = !r_enc_full;
    assign bus.dec_ready_out = !r_dec_full;

    // Tie goes to whichever side was not granted last.
    assign w_pick_dec  = r_dec_full && (!r_enc_full || !r_last_dec);
    assign w_grant     = (r_state == ST_IDLE) && bus.keys_valid_in && !bus.eng_busy_in
                         && (r_enc_full || r_dec_full);
    assign w_base      = w_pick_dec ? r_dec_buf      : r_enc_buf;
    assign w_exp       = w_pick_dec ? bus.local_d_in : bus.e_in;
    assign w_mod       = w_pick_dec ? bus.local_N_in : bus.other_N_in;
    assign w_range_err = (w_base >= w_mod);

    always_comb begin
        w_fin     = 1'b0;
        w_fin_dec = r_gnt_dec;
        w_fin_err = 1'b0;
        w_fin_res = '0;
        if (w_grant && w_range_err) begin
            w_fin     = 1'b1;
            w_fin_dec = w_pick_dec;
            w_fin_err = 1'b1;
        end else if (r_state == ST_WAIT) begin
            if (bus.eng_valid_in) begin
                w_fin     = 1'b1;
                w_fin_res = bus.eng_result_in;
            end else if (r_timed_out) begin
                w_fin     = 1'b1;
                w_fin_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state            <= ST_IDLE;
            r_enc_full         <= 1'b0;
            r_dec_full         <= 1'b0;
            r_enc_buf          <= '0;
            r_dec_buf          <= '0;
            r_last_dec         <= 1'b1;
            r_gnt_dec          <= 1'b0;
            bus.eng_valid_out  <= 1'b0;
            bus.eng_base_out   <= '0;
            bus.eng_exp_out    <= '0;
            bus.eng_mod_out    <= '0;
            bus.enc_valid_out  <= 1'b0;
            bus.enc_result_out <= '0;
            bus.enc_error_out  <= 1'b0;
            bus.dec_valid_out  <= 1'b0;
            bus.dec_result_out <= '0;
            bus.dec_error_out  <= 1'b0;
        end else begin
            bus.eng_valid_out <= 1'b0;
            bus.enc_valid_out <= 1'b0;
            bus.dec_valid_out <= 1'b0;

            if (bus.enc_valid_in && !r_enc_full) begin
                r_enc_full <= 1'b1;
                r_enc_buf  <= bus.enc_msg_in;
            end
            if (bus.dec_valid_in && !r_dec_full) begin
                r_dec_full <= 1'b1;
                r_dec_buf  <= bus.dec_msg_in;
            end

            if (w_fin) begin
                if (w_fin_dec) begin
                    bus.dec_valid_out  <= 1'b1;
                    bus.dec_result_out <= w_fin_res;
                    bus.dec_error_out  <= w_fin_err;
                end else begin
                    bus.enc_valid_out  <= 1'b1;
                    bus.enc_result_out <= w_fin_res;
                    bus.enc_error_out  <= w_fin_err;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_gnt_dec  <= w_pick_dec;
                        r_last_dec <= w_pick_dec;
                        if (w_range_err) begin
                            r_state <= ST_DONE;
                        end else begin
                            bus.eng_base_out  <= w_base;
                            bus.eng_exp_out   <= w_exp;
                            bus.eng_mod_out   <= w_mod;
                            bus.eng_valid_out <= 1'b1;
                            r_state           <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_fin) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (r_gnt_dec) r_dec_full <= 1'b0;
                    else           r_enc_full <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MODEXP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Counter idles at zero outside WAIT, so every WAIT entry starts fresh.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wait_cnt        <= '0;
            r_timed_out       <= 1'b0;
            bus.eng_abort_out <= 1'b0;
        end else begin
            bus.eng_abort_out <= 1'b0;
            if (r_state != ST_WAIT) begin
                r_wait_cnt  <= '0;
                r_timed_out <= 1'b0;
            end else if (!bus.eng_valid_in && !r_timed_out) begin
                if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus.eng_abort_out <= 1'b1;
                    r_timed_out       <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign r_timed_out        = 1'b0;
    assign bus.eng_abort_out  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_modexp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_modexp_arbiter
// Purpose  : Scoreboard bench for modexp_arbiter with a behavioural engine.
// Revision : 1.0
// ============================================================================
module tb_modexp_arbiter;
    localparam int W    = 64;
    localparam int TOUT = 50;
    localparam logic [W-1:0] E_PUB = 64'd3;
    localparam logic [W-1:0] N_OTH = 64'd33;
    localparam logic [W-1:0] D_LOC = 64'd7;
    localparam logic [W-1:0] N_LOC = 64'd55;

    typedef struct { logic [W-1:0] res; logic err; } res_t;
    typedef struct { logic [W-1:0] base; logic [W-1:0] ex; logic [W-1:0] md; } job_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modexp_arbiter_if #(.WIDTH(W)) bus ();
    modexp_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    res_t enc_q[$];
    res_t dec_q[$];
    job_t job_q[$];
    job_t mj;
    res_t mr;

    int checks = 0, errors = 0;
    int cyc = 0, issue_cnt = 0, issue_cyc = 0, dec_done_cyc = 0, abort_cnt = 0;
    int eng_lat = 10, eng_cnt = 0;
    bit silent = 1'b0, busy_force = 1'b0;
    logic [W-1:0] eng_res;

    assign bus.eng_busy_in = busy_force | (eng_cnt != 0);

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
        logic [2*W-1:0] r, x;
        r = 1;
        x = {{W{1'b0}}, b} % {{W{1'b0}}, m};
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % {{W{1'b0}}, m};
            x = (x * x) % {{W{1'b0}}, m};
        end
        return r[W-1:0];
    endfunction

    // Expected outcome of one request; tout marks a job the engine never answers.
    task automatic expect_req(input bit is_dec, input logic [W-1:0] m, input bit tout);
        job_t j;
        res_t r;
        j.base = m;
        j.ex   = is_dec ? D_LOC : E_PUB;
        j.md   = is_dec ? N_LOC : N_OTH;
        if (m >= j.md) begin
            r.res = '0;
            r.err = 1'b1;
        end else begin
            job_q.push_back(j);
            r.res = tout ? '0 : mexp(m, j.ex, j.md);
            r.err = tout;
        end
        if (is_dec) dec_q.push_back(r);
        else        enc_q.push_back(r);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model and output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        bus.eng_valid_in = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
                bus.eng_valid_in  = 1'b1;
                bus.eng_result_in = eng_res;
            end
        end
        if (bus.eng_valid_out) begin
            issue_cnt++;
            issue_cyc = cyc;
            if (job_q.size() == 0) begin
                chk("job_unexpected", 1, 0);
            end else begin
                mj = job_q.pop_front();
                chk("eng_base", bus.eng_base_out, mj.base);
                chk("eng_exp",  bus.eng_exp_out,  mj.ex);
                chk("eng_mod",  bus.eng_mod_out,  mj.md);
            end
            eng_res = mexp(bus.eng_base_out, bus.eng_exp_out, bus.eng_mod_out);
            if (!silent) eng_cnt = eng_lat;
        end
        if (bus.enc_valid_out) begin
            if (enc_q.size() == 0) chk("enc_unexpected", 1, 0);
            else begin
                mr = enc_q.pop_front();
                chk("enc_result", bus.enc_result_out, mr.res);
                chk("enc_error",  {63'd0, bus.enc_error_out}, {63'd0, mr.err});
            end
        end
        if (bus.dec_valid_out) begin
            dec_done_cyc = cyc;
            if (dec_q.size() == 0) chk("dec_unexpected", 1, 0);
            else begin
                mr = dec_q.pop_front();
                chk("dec_result", bus.dec_result_out, mr.res);
                chk("dec_error",  {63'd0, bus.dec_error_out}, {63'd0, mr.err});
            end
        end
        if (bus.eng_abort_out) abort_cnt++;
    end

    task automatic req(input bit de, input logic [W-1:0] em, input bit dd,
                       input logic [W-1:0] dm, output int acc);
        @(negedge clk);
        bus.enc_valid_in = de;
        bus.enc_msg_in   = em;
        bus.dec_valid_in = dd;
        bus.dec_msg_in   = dm;
        @(negedge clk);
        bus.enc_valid_in = 1'b0;
        bus.dec_valid_in = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_issue(input int prev);
        int n = 0;
        while (issue_cnt == prev && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("issue_timeout", {63'd0, (n < 200)}, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((enc_q.size() + dec_q.size() + job_q.size()) != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", {63'd0, (n < 1000)}, 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int acc, n0, k;
        bus.keys_valid_in = 1'b1;
        bus.e_in          = E_PUB;
        bus.other_N_in    = N_OTH;
        bus.local_d_in    = D_LOC;
        bus.local_N_in    = N_LOC;
        bus.enc_valid_in  = 1'b0;
        bus.dec_valid_in  = 1'b0;
        bus.enc_msg_in    = '0;
        bus.dec_msg_in    = '0;

        repeat (3) @(negedge clk);
        chk("rst_enc_ready", {63'd0, bus.enc_ready_out}, 1);
        chk("rst_dec_ready", {63'd0, bus.dec_ready_out}, 1);
        chk("rst_eng_valid", {63'd0, bus.eng_valid_out}, 0);
        chk("rst_enc_valid", {63'd0, bus.enc_valid_out}, 0);
        chk("rst_dec_valid", {63'd0, bus.dec_valid_out}, 0);
        chk("rst_abort",     {63'd0, bus.eng_abort_out}, 0);
        chk("rst_eng_mod",   bus.eng_mod_out, 0);
        rst_n = 1'b1;

        // Single encrypt job: 5^3 mod 33 = 26.
        n0 = issue_cnt;
        expect_req(1'b0, 64'd5, 1'b0);
        req(1'b1, 64'd5, 1'b0, '0, acc);
        chk("enc_ready_low", {63'd0, bus.enc_ready_out}, 0);
        wait_issue(n0);
        chk("issue_latency", W'(issue_cyc - acc), 1);
        drain();
        chk("enc_result_hold", bus.enc_result_out, 64'd26);
        chk("enc_ready_back", {63'd0, bus.enc_ready_out}, 1);

        // Asynchronous reset while a job is in flight.
        job_q.push_back('{base: 64'd9, ex: E_PUB, md: N_OTH});
        req(1'b1, 64'd9, 1'b0, '0, acc);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_enc_ready", {63'd0, bus.enc_ready_out}, 1);
        chk("arst_eng_base",  bus.eng_base_out, 0);
        k = 0;
        while (eng_cnt != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous requests twice: ENC, DEC, ENC, DEC.
        expect_req(1'b0, 64'd2, 1'b0);
        expect_req(1'b1, 64'd3, 1'b0);
        req(1'b1, 64'd2, 1'b1, 64'd3, acc);
        drain();
        expect_req(1'b0, 64'd4, 1'b0);
        expect_req(1'b1, 64'd6, 1'b0);
        req(1'b1, 64'd4, 1'b1, 64'd6, acc);
        drain();

        // Range check: msg equal to / above modulus, and modulus-1.
        n0 = issue_cnt;
        expect_req(1'b1, N_LOC, 1'b0);
        req(1'b0, '0, 1'b1, N_LOC, acc);
        drain();
        chk("range_latency", W'(dec_done_cyc - acc), 1);
        chk("range_no_issue", W'(issue_cnt), W'(n0));
        expect_req(1'b0, 64'd40, 1'b0);
        req(1'b1, 64'd40, 1'b0, '0, acc);
        drain();
        expect_req(1'b1, 64'd54, 1'b0);
        req(1'b0, '0, 1'b1, 64'd54, acc);
        drain();

        // Keys not valid: both buffers held, then ENC wins once keys return.
        bus.keys_valid_in = 1'b0;
        n0 = issue_cnt;
        req(1'b1, 64'd1, 1'b1, 64'd1, acc);
        repeat (10) @(negedge clk);
        chk("keys_no_issue", W'(issue_cnt), W'(n0));
        chk("keys_enc_ready", {63'd0, bus.enc_ready_out}, 0);
        chk("keys_dec_ready", {63'd0, bus.dec_ready_out}, 0);
        expect_req(1'b0, 64'd1, 1'b0);
        expect_req(1'b1, 64'd1, 1'b0);
        bus.keys_valid_in = 1'b1;
        k = cyc;
        wait_issue(n0);
        chk("keys_latency", W'(issue_cyc - k), 1);
        drain();

        // Busy engine holds the grant off until it drops.
        busy_force = 1'b1;
        n0 = issue_cnt;
        expect_req(1'b0, 64'd7, 1'b0);
        req(1'b1, 64'd7, 1'b0, '0, acc);
        repeat (20) @(negedge clk);
        chk("busy_no_issue", W'(issue_cnt), W'(n0));
        busy_force = 1'b0;
        k = cyc;
        wait_issue(n0);
        chk("busy_latency", W'(issue_cyc - k), 1);
        drain();

`ifdef MODEXP_TIMEOUT_EN
        silent = 1'b1;
        expect_req(1'b0, 64'd5, 1'b1);
        req(1'b1, 64'd5, 1'b0, '0, acc);
        drain();
        chk("timeout_abort_cnt", W'(abort_cnt), 1);
        silent  = 1'b0;
        eng_lat = TOUT;
        expect_req(1'b0, 64'd5, 1'b0);
        req(1'b1, 64'd5, 1'b0, '0, acc);
        drain();
        chk("expiry_tie_abort_cnt", W'(abort_cnt), 1);
        chk("expiry_tie_result", bus.enc_result_out, 64'd26);
`else
        chk("abort_never", W'(abort_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/modexp_arbiter.md
# modexp_arbiter

Arbiter and sequencer that shares one modular-exponentiation engine between the encrypt path (UART ingress, public key of peer) and the decrypt path (SPI ingress, local private key). Each requester gets a one-entry request buffer; the arbiter selects operands and issues one job to the engine at a time with round-robin fairness. It returns the result to the owning requester. It sits in the top level between the UART/SPI controllers and the modexp engine, and is enabled once key generation reaches steady state.

## Interface
- WIDTH, 512, operand/modulus/result width in bits
- TIMEOUT_CYCLES, 2_000_000, engine watchdog limit (used only with MODEXP_TIMEOUT_EN)

- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- keys_valid_in  input  1  key material stable; no grants while low
- e_in, local_d_in, local_N_in, other_N_in  input  WIDTH  public exponent, private exponent, local modulus, peer modulus
- enc_valid_in / dec_valid_in  input  1  request strobe
- enc_msg_in / dec_msg_in  input  WIDTH  base operand
- enc_ready_out / dec_ready_out  output  1  request buffer empty
- enc_valid_out / dec_valid_out  output  1  one-cycle completion pulse
- enc_result_out / dec_result_out  output  WIDTH  result, held until next completion for that requester
- enc_error_out / dec_error_out  output  1  qualifies valid_out; result forced 0
- eng_valid_out  output  1  one-cycle job start
- eng_base_out, eng_exp_out, eng_mod_out  output  WIDTH  registered job operands
- eng_busy_in  input  1  engine busy
- eng_valid_in  input  1  engine done pulse
- eng_result_in  input  WIDTH  engine result
- eng_abort_out  output  1  one-cycle abort pulse

## Operation
- Reset: state IDLE; all outputs 0 except enc_ready_out = dec_ready_out = 1; buffers empty; last_grant = DEC.
- Accept: valid_in & ready_out at an edge latches msg into that requester's buffer; ready_out falls next cycle. valid_in while not ready is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE -> ISSUE: keys_valid_in & !eng_busy_in & any buffer full. Grant goes to the sole full buffer. On a tie, grant goes to the requester not granted last, so ENC wins the first tie after reset. last_grant updates on the grant.
- Grant operands: ENC = (msg, e_in, other_N_in); DEC = (msg, local_d_in, local_N_in). Key inputs are sampled at the IDLE->ISSUE edge.
- Range check at grant: if msg >= selected modulus (unsigned, full WIDTH), no engine job. Go IDLE -> DONE with error = 1 and result 0.
- ISSUE: eng_valid_out = 1 for exactly one cycle; -> WAIT.
- WAIT: on eng_valid_in, capture eng_result_in; -> DONE.
- DONE (one cycle): granted requester's valid_out = 1 with result/error. Its buffer clears at the same edge, so ready_out is high in this cycle's successor. -> IDLE.
- keys_valid_in falling mid-job: the in-flight job completes normally; no new grants until it returns high.
- eng_valid_in outside WAIT is ignored.

## Timing
- Accept at edge N: eng_valid_out is high in cycle N+2 (idle engine, keys valid).
- eng_valid_in in cycle M: requester valid_out is high in cycle M+1. ready_out is high from cycle M+2. A new request from the same side is accepted at the M+2 edge; the other side's pending request issues at M+3.
- Range-error path: valid_out with error = 1 in cycle N+2.
- Back-to-back requests from both sides alternate grants strictly.
- Async reset mid-job: immediate return to reset values; the engine is not aborted (the top level resets it with the same reset).

## Configuration
- MODEXP_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT (cleared on entry).
  - If TIMEOUT_CYCLES cycles elapse without eng_valid_in: eng_abort_out pulses one cycle, then DONE with error = 1 and result 0.
  - eng_valid_in in the same cycle as expiry takes priority (normal result).
- Not defined: no counter; WAIT waits indefinitely; eng_abort_out is constant 0.

## Test plan
- Reset, keys_valid_in = 1, enc request msg = 5, e = 3, other_N = 33, model engine returns 26 after 10 cycles -> eng_exp_out = 3, eng_mod_out = 33; enc_valid_out pulse with result 26, error 0.
- Enc and dec valid in the same cycle, then both again after completion -> grant order ENC, DEC, ENC, DEC; dec job uses local_d_in/local_N_in.
- dec msg = local_N_in -> no eng_valid_out; dec_valid_out with error 1, result 0, two cycles after accept.
- keys_valid_in = 0 with both buffers full -> no eng_valid_out, ready_outs stay 0. Raise keys_valid_in -> ENC issues two cycles later.
- eng_busy_in = 1 for 20 cycles with a pending request -> eng_valid_out is asserted only in the second cycle after eng_busy_in falls.
- MODEXP_TIMEOUT_EN with TIMEOUT_CYCLES = 50 and a silent engine -> eng_abort_out pulse, then enc_valid_out with error 1. Repeat with eng_valid_in on the expiry cycle -> error 0, engine result returned.
